// File: rtl/clic_tb_pkg.sv
// clic_tb_pkg: shared types and constants for the CLIC testbench pseudo-core.
package clic_tb_pkg;

  localparam int XLEN = 32;

  typedef logic [1:0] priv_lvl_t;

  localparam priv_lvl_t PRIV_U = 2'b00;
  localparam priv_lvl_t PRIV_S = 2'b01;
  localparam priv_lvl_t PRIV_M = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    TRAP,
    HALT
  } core_state_e;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CSRW = 3'd1;
  localparam logic [2:0] OP_MRET = 3'd2;
  localparam logic [2:0] OP_SRET = 3'd3;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_SEPC    = 12'h141;

  localparam logic [XLEN-1:0] BOOT_BASE  = 32'h0000;
  localparam logic [XLEN-1:0] MTVEC_BASE = 32'h1000;
  localparam logic [XLEN-1:0] STVEC_BASE = 32'h2000;

  typedef struct packed {
    logic [2:0]      op;
    logic [11:0]     csr;
    logic [XLEN-1:0] data;
  } instruction_t;

  // Increment stays inside the 4K-word bank.
  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:12], pc[11:0] + 12'd1};
  endfunction

endpackage

// File: rtl/clic_tb_core_if.sv
// clic_tb_core_if: ROM fetch, interrupt handshake and CSR strobe
// bundle between the pseudo-core and its environment.
interface clic_tb_core_if
  import clic_tb_pkg::*;
#(
  parameter int ID_W = 5
) ();

  logic            fetch_en_i;
  logic [XLEN-1:0] instr_addr_o;
  instruction_t    instr_rdata_i;
  logic            irq_valid_i;
  logic [ID_W-1:0] irq_id_i;
  priv_lvl_t       irq_priv_i;
  logic            irq_ready_o;
  logic            csr_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  priv_lvl_t       priv_o;
  logic [ID_W-1:0] irq_id_o;
  logic            halted_o;

  modport master (
    input  fetch_en_i,
    input  instr_rdata_i,
    input  irq_valid_i,
    input  irq_id_i,
    input  irq_priv_i,
    output instr_addr_o,
    output irq_ready_o,
    output csr_we_o,
    output csr_addr_o,
    output csr_wdata_o,
    output priv_o,
    output irq_id_o,
    output halted_o
  );

  modport slave (
    output fetch_en_i,
    output instr_rdata_i,
    output irq_valid_i,
    output irq_id_i,
    output irq_priv_i,
    input  instr_addr_o,
    input  irq_ready_o,
    input  csr_we_o,
    input  csr_addr_o,
    input  csr_wdata_o,
    input  priv_o,
    input  irq_id_o,
    input  halted_o
  );

endinterface

// File: rtl/clic_tb_core_status.sv
// clic_tb_core_status: privilege, xIE/xPIE/xPP and xEPC state plus
// the interrupt acceptance decision.
module clic_tb_core_status
  import clic_tb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic            i_trap,
  input  logic            i_trap_m,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_mret,
  input  logic            i_sret,
  input  logic            i_irq_valid,
  input  priv_lvl_t       i_irq_priv,
  output logic            o_irq_take,
  output priv_lvl_t       o_priv,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_sepc
);

  priv_lvl_t       r_priv;
  priv_lvl_t       r_mpp;
  priv_lvl_t       r_spp;
  logic            r_mie;
  logic            r_sie;
  logic            r_mpie;
  logic            r_spie;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_sepc;
  logic            w_xie;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_priv <= PRIV_M;
      r_mpp  <= PRIV_M;
      r_spp  <= PRIV_S;
      r_mie  <= 1'b0;
      r_sie  <= 1'b0;
      r_mpie <= 1'b0;
      r_spie <= 1'b0;
      r_mepc <= '0;
      r_sepc <= '0;
    end else if (i_trap && i_trap_m) begin
      r_mepc <= i_trap_pc;
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
      r_mpp  <= r_priv;
      r_priv <= PRIV_M;
    end else if (i_trap) begin
      r_sepc <= i_trap_pc;
      r_spie <= r_sie;
      r_sie  <= 1'b0;
      r_spp  <= r_priv;
      r_priv <= PRIV_S;
    end else if (i_mret) begin
      r_priv <= r_mpp;
      r_mie  <= r_mpie;
      r_mpp  <= PRIV_U;
    end else if (i_sret) begin
      r_priv <= r_spp;
      r_sie  <= r_spie;
    end else if (i_csr_we) begin
      unique case (1'b1)
        (i_csr_addr == CSR_MSTATUS): r_mie  <= i_csr_wdata[3];
        (i_csr_addr == CSR_SSTATUS): r_sie  <= i_csr_wdata[1];
        (i_csr_addr == CSR_MEPC):    r_mepc <= i_csr_wdata;
        (i_csr_addr == CSR_SEPC):    r_sepc <= i_csr_wdata;
        default: ;
      endcase
    end
  end

  // U mode has no local enable: only higher-privilege irqs get in.
  always_comb begin
    w_xie = 1'b0;
    unique case (1'b1)
      (r_priv == PRIV_M): w_xie = r_mie;
      (r_priv == PRIV_S): w_xie = r_sie;
      default:            w_xie = 1'b0;
    endcase
    o_irq_take = i_irq_valid &&
                 ((i_irq_priv > r_priv) ||
                  ((i_irq_priv == r_priv) && w_xie));
  end

  assign o_priv = r_priv;
  assign o_mepc = r_mepc;
  assign o_sepc = r_sepc;

endmodule

// File: rtl/clic_tb_core.sv
// clic_tb_core: two-cycle pseudo-core fetching from the banked ROM
// and accepting CLIC interrupts per privilege level.
module clic_tb_core
  import clic_tb_pkg::*;
#(
  parameter int              ID_W      = 5,
  parameter logic [XLEN-1:0] BOOT_ADDR = BOOT_BASE,
  parameter logic [XLEN-1:0] MTVEC     = MTVEC_BASE,
  parameter logic [XLEN-1:0] STVEC     = STVEC_BASE
) (
  input logic            clk_i,
  input logic            rst_i,
  clic_tb_core_if.master bus
);

  core_state_e     r_state;
  core_state_e     w_next;
  logic [XLEN-1:0] r_pc;
  logic [ID_W-1:0] r_irq_id;
  instruction_t    w_ins;
  logic            w_take;
  logic            w_trap;
  logic            w_we;
  logic            w_adv;
  logic            w_mret;
  logic            w_sret;
  logic            w_ill;
  logic            w_trap_m;
  priv_lvl_t       w_priv;
  logic [XLEN-1:0] w_mepc;
  logic [XLEN-1:0] w_sepc;

  assign w_ins    = bus.instr_rdata_i;
  assign w_trap_m = (bus.irq_priv_i == PRIV_M);

  always_comb begin
    w_next = r_state;
    w_trap = 1'b0;
    w_we   = 1'b0;
    w_adv  = 1'b0;
    w_mret = 1'b0;
    w_sret = 1'b0;
    w_ill  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.fetch_en_i) w_next = FETCH;
      end
      FETCH: begin
        w_trap = w_take;
        w_next = w_take ? TRAP : EXEC;
      end
      EXEC: begin
        unique case (1'b1)
          (w_ins.op == OP_NOP):  w_adv = 1'b1;
          (w_ins.op == OP_CSRW): begin
            w_adv = 1'b1;
            w_we  = 1'b1;
          end
          (w_ins.op == OP_MRET): w_mret = 1'b1;
          (w_ins.op == OP_SRET): w_sret = 1'b1;
          default:               w_ill  = 1'b1;
        endcase
        if (w_ill)
          w_next = HALT;
        else if (bus.fetch_en_i)
          w_next = FETCH;
        else
          w_next = IDLE;
      end
      TRAP:    w_next = FETCH;
      default: w_next = HALT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_pc     <= BOOT_ADDR;
      r_irq_id <= '0;
    end else begin
      r_state <= w_next;
      if (w_trap) begin
        r_pc     <= w_trap_m ? MTVEC : STVEC;
        r_irq_id <= bus.irq_id_i;
      end else if (w_mret) begin
        r_pc <= w_mepc;
      end else if (w_sret) begin
        r_pc <= w_sepc;
      end else if (w_adv) begin
        r_pc <= pc_inc(r_pc);
      end
    end
  end

  clic_tb_core_status u_status (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_csr_we    (w_we),
    .i_csr_addr  (w_ins.csr),
    .i_csr_wdata (w_ins.data),
    .i_trap      (w_trap),
    .i_trap_m    (w_trap_m),
    .i_trap_pc   (r_pc),
    .i_mret      (w_mret),
    .i_sret      (w_sret),
    .i_irq_valid (bus.irq_valid_i),
    .i_irq_priv  (bus.irq_priv_i),
    .o_irq_take  (w_take),
    .o_priv      (w_priv),
    .o_mepc      (w_mepc),
    .o_sepc      (w_sepc)
  );

  assign bus.instr_addr_o = r_pc;
  assign bus.irq_ready_o  = w_trap;
  assign bus.csr_we_o     = w_we;
  assign bus.csr_addr_o   = w_we ? w_ins.csr : 12'h000;
  assign bus.csr_wdata_o  = w_we ? w_ins.data : '0;
  assign bus.priv_o       = w_priv;
  assign bus.irq_id_o     = r_irq_id;
  assign bus.halted_o     = (r_state == HALT);

endmodule

// File: tb/tb_clic_tb_core.sv
// tb_clic_tb_core: directed and random checks of clic_tb_core against
// an instruction-level reference model.
module tb_clic_tb_core;
  import clic_tb_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  clic_tb_core_if #(.ID_W(5)) bus ();

  clic_tb_core #(
    .ID_W      (5),
    .BOOT_ADDR (32'h0000),
    .MTVEC     (32'h1000),
    .STVEC     (32'h2000)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  instruction_t rom [logic [31:0]];

  function automatic instruction_t rom_rd(input logic [31:0] a);
    instruction_t d;
    d = '0;
    if (rom.exists(a)) d = rom[a];
    return d;
  endfunction

  function automatic instruction_t mk(
    input logic [2:0] op, input logic [11:0] c, input logic [31:0] d
  );
    instruction_t r;
    r.op   = op;
    r.csr  = c;
    r.data = d;
    return r;
  endfunction

  // ROM answers one cycle after the address
  always @(posedge clk_i) bus.instr_rdata_i <= rom_rd(bus.instr_addr_o);

  int checks   = 0;
  int failures = 0;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_EXEC  = 2;
  localparam int P_TRAP  = 3;
  localparam int P_HALT  = 4;

  int          ph;
  logic [31:0] m_pc, m_mepc, m_sepc;
  logic [1:0]  m_priv, m_mpp, m_spp;
  bit          m_mie, m_sie, m_mpie, m_spie;
  logic [4:0]  m_id;

  int          cyc;
  int          we_cyc;
  logic [31:0] obs_addr [64];
  int          rdy_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrap_inc(input logic [31:0] a);
    return (a & 32'hFFFF_F000) | ((a + 32'd1) & 32'h0000_0FFF);
  endfunction

  function automatic bit m_take();
    bit en;
    en = (m_priv == 2'b11) ? m_mie : (m_priv == 2'b01) ? m_sie : 1'b0;
    return bus.irq_valid_i &&
           ((bus.irq_priv_i > m_priv) ||
            ((bus.irq_priv_i == m_priv) && en));
  endfunction

  task automatic model_reset();
    ph     = P_IDLE;
    m_pc   = 32'h0;
    m_mepc = 32'h0;
    m_sepc = 32'h0;
    m_priv = 2'b11;
    m_mpp  = 2'b11;
    m_spp  = 2'b01;
    m_mie  = 1'b0;
    m_sie  = 1'b0;
    m_mpie = 1'b0;
    m_spie = 1'b0;
    m_id   = 5'd0;
  endtask

  task automatic check_outs();
    instruction_t ins;
    bit we;
    ins = rom_rd(m_pc);
    we  = (ph == P_EXEC) && (ins.op == OP_CSRW);
    if (cyc < 64) obs_addr[cyc] = bus.instr_addr_o;
    if (bus.irq_ready_o) rdy_q.push_back(cyc);
    if (bus.csr_we_o && we_cyc < 0) we_cyc = cyc;
    chk("addr", bus.instr_addr_o, m_pc);
    chk("ready", 32'(bus.irq_ready_o),
        32'((ph == P_FETCH) && m_take()));
    chk("csr_we", 32'(bus.csr_we_o), 32'(we));
    chk("csr_addr", 32'(bus.csr_addr_o), we ? 32'(ins.csr) : 32'd0);
    chk("csr_wdata", bus.csr_wdata_o, we ? ins.data : 32'd0);
    chk("priv", 32'(bus.priv_o), 32'(m_priv));
    chk("irq_id", 32'(bus.irq_id_o), 32'(m_id));
    chk("halted", 32'(bus.halted_o), 32'(ph == P_HALT));
  endtask

  task automatic model_adv();
    instruction_t ins;
    ins = rom_rd(m_pc);
    case (ph)
      P_IDLE: if (bus.fetch_en_i) ph = P_FETCH;
      P_FETCH: begin
        if (m_take()) begin
          m_id = bus.irq_id_i;
          if (bus.irq_priv_i == 2'b11) begin
            m_mepc = m_pc;
            m_mpie = m_mie;
            m_mie  = 1'b0;
            m_mpp  = m_priv;
            m_priv = 2'b11;
            m_pc   = 32'h1000;
          end else begin
            m_sepc = m_pc;
            m_spie = m_sie;
            m_sie  = 1'b0;
            m_spp  = m_priv;
            m_priv = 2'b01;
            m_pc   = 32'h2000;
          end
          ph = P_TRAP;
        end else begin
          ph = P_EXEC;
        end
      end
      P_EXEC: begin
        ph = bus.fetch_en_i ? P_FETCH : P_IDLE;
        case (ins.op)
          OP_NOP: m_pc = wrap_inc(m_pc);
          OP_CSRW: begin
            if (ins.csr == 12'h300) m_mie = ins.data[3];
            if (ins.csr == 12'h100) m_sie = ins.data[1];
            if (ins.csr == 12'h341) m_mepc = ins.data;
            if (ins.csr == 12'h141) m_sepc = ins.data;
            m_pc = wrap_inc(m_pc);
          end
          OP_MRET: begin
            m_pc   = m_mepc;
            m_priv = m_mpp;
            m_mie  = m_mpie;
            m_mpp  = 2'b00;
          end
          OP_SRET: begin
            m_pc   = m_sepc;
            m_priv = m_spp;
            m_sie  = m_spie;
          end
          default: ph = P_HALT;
        endcase
      end
      P_TRAP:  ph = P_FETCH;
      default: ph = P_HALT;
    endcase
  endtask

  task automatic step();
    @(negedge clk_i);
    check_outs();
    @(posedge clk_i);
    model_adv();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    bus.fetch_en_i   = 1'b0;
    bus.irq_valid_i  = 1'b0;
    bus.irq_priv_i   = 2'b11;
    bus.irq_id_i     = 5'd0;
    model_reset();
    cyc    = 0;
    we_cyc = -1;
    rdy_q.delete();
    @(posedge clk_i);
    #1;
    check_outs();
    rst_i = 1'b0;
  endtask

  task automatic load_boot();
    rom.delete();
    rom[32'h0002] = mk(OP_CSRW, 12'h300, 32'h8);
    rom[32'h0003] = mk(OP_CSRW, 12'h300, 32'h0);
    rom[32'h0006] = mk(OP_CSRW, 12'h141, 32'h3000);
    rom[32'h0007] = mk(OP_SRET, 12'h000, 32'h0);
    rom[32'h1000] = mk(OP_MRET, 12'h000, 32'h0);
  endtask

  initial begin
    logic [11:0] csrs [5];
    csrs = '{12'h300, 12'h100, 12'h341, 12'h141, 12'h305};

    // boot, M irq, masking, preemption from S
    load_boot();
    do_reset();
    bus.fetch_en_i = 1'b1;
    for (int k = 0; k < 26; k++) begin
      bus.irq_valid_i = (k == 7) || (k == 13) || (k == 15) || (k == 21);
      bus.irq_priv_i  = (k == 15) ? 2'b01 : 2'b11;
      bus.irq_id_i    = (k == 21) ? 5'd9 : 5'd7;
      step();
    end
    chk("boot_we_cyc", 32'(we_cyc), 32'd6);
    chk("boot_a1", obs_addr[1], 32'h0);
    chk("boot_a3", obs_addr[3], 32'h1);
    chk("boot_a5", obs_addr[5], 32'h2);
    chk("vec_m", obs_addr[9], 32'h1000);
    chk("mret_ret", obs_addr[11], 32'h3);
    chk("sret_tgt", obs_addr[21], 32'h3000);
    chk("rdy_cnt", 32'(rdy_q.size()), 32'd2);
    chk("rdy_first", 32'(rdy_q[0]), 32'd7);
    chk("rdy_preempt", 32'(rdy_q[1]), 32'd21);
    chk("preempt_ret", obs_addr[25], 32'h3000);
    chk("preempt_priv", 32'(bus.priv_o), 32'h1);
    chk("preempt_id", 32'(bus.irq_id_o), 32'd9);

    // reset while the CSRW strobe is up
    do_reset();
    bus.fetch_en_i = 1'b1;
    for (int k = 0; k < 6; k++) step();
    @(negedge clk_i);
    check_outs();
    rst_i = 1'b1;
    #1;
    chk("rst_cut_we", 32'(bus.csr_we_o), 32'd0);
    chk("rst_addr", bus.instr_addr_o, 32'h0);
    chk("rst_priv", 32'(bus.priv_o), 32'h3);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // bank wrap, U-mode S irq, illegal op halt
    rom.delete();
    rom[32'h0000] = mk(OP_CSRW, 12'h341, 32'h0FFF);
    rom[32'h0001] = mk(OP_MRET, 12'h000, 32'h0);
    rom[32'h2000] = mk(3'd7, 12'h000, 32'h0);
    do_reset();
    bus.fetch_en_i  = 1'b1;
    bus.irq_valid_i = 1'b1;
    bus.irq_priv_i  = 2'b01;
    bus.irq_id_i    = 5'd5;
    for (int k = 0; k < 20; k++) step();
    chk("wrap_from", obs_addr[5], 32'h0FFF);
    chk("wrap_to", obs_addr[7], 32'h0000);
    chk("s_rdy_cnt", 32'(rdy_q.size()), 32'd1);
    chk("s_rdy_cyc", 32'(rdy_q[0]), 32'd11);
    chk("halt_frozen", obs_addr[19], 32'h2000);
    chk("halt_set", 32'(bus.halted_o), 32'd1);
    chk("halt_priv", 32'(bus.priv_o), 32'h1);
    do_reset();
    chk("halt_clr", 32'(bus.halted_o), 32'd0);

    // random programs and interrupt traffic
    rom.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 64; i++) begin
        int r;
        logic [11:0] c;
        logic [31:0] d;
        logic [31:0] a;
        a = (32'(b) << 12) | 32'(i);
        r = int'($urandom_range(0, 9));
        c = csrs[$urandom_range(0, 4)];
        if (c == 12'h341 || c == 12'h141)
          d = {18'd0, 2'($urandom_range(0, 3)), 6'd0,
               6'($urandom_range(0, 63))};
        else
          d = $urandom();
        if (r < 4)      rom[a] = mk(OP_NOP, 12'h000, 32'h0);
        else if (r < 8) rom[a] = mk(OP_CSRW, c, d);
        else if (r < 9) rom[a] = mk(OP_MRET, 12'h000, 32'h0);
        else            rom[a] = mk(OP_SRET, 12'h000, 32'h0);
      end
    end
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      bus.fetch_en_i  = ($urandom_range(0, 19) != 0);
      bus.irq_valid_i = ($urandom_range(0, 3) == 0);
      bus.irq_priv_i  = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
      bus.irq_id_i    = 5'($urandom_range(0, 31));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
